// File: rtl/fir_tap_arbiter_if.sv
// Request/response bundle between the FIR tap-RAM arbiter and its two requesters
// (AXI-Lite coefficient path and FIR engine tap fetch).
interface fir_tap_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Handshake: a requester raises *_req with its payload and holds both unchanged
  // until it samples *_gnt high at a rising edge; the access happens in that cycle
  // and its response (cfg_done / eng_rvalid) is presented exactly one cycle later.
  logic              cfg_req;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              cfg_gnt;
  logic              cfg_done;
  logic              cfg_err;
  logic [DATA_W-1:0] cfg_rdata;
  logic              eng_req;
  logic [3:0]        eng_idx;
  logic              eng_gnt;
  logic              eng_rvalid;
  logic [DATA_W-1:0] eng_rdata;
  logic              state_dbg;  // 0 = INIT (RAM clear), 1 = RUN

  modport master (
    output cfg_req, cfg_we, cfg_addr, cfg_wdata, eng_req, eng_idx,
    input  cfg_gnt, cfg_done, cfg_err, cfg_rdata, eng_gnt, eng_rvalid, eng_rdata, state_dbg
  );

  modport slave (
    input  cfg_req, cfg_we, cfg_addr, cfg_wdata, eng_req, eng_idx,
    output cfg_gnt, cfg_done, cfg_err, cfg_rdata, eng_gnt, eng_rvalid, eng_rdata, state_dbg
  );
endinterface

// File: rtl/fir_tap_arbiter.sv
// Owns the single-port FIR tap RAM: clears it after reset, then shares it one access
// per cycle between the AXI-Lite coefficient path and the engine tap fetch.
module fir_tap_arbiter #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int pTAP_BASE   = 'h020,
  parameter int pSTARVE     = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   engine_busy,
  fir_tap_arbiter_if.slave       bus,
  output logic                   init_done,
  output logic [15:0]            conflict_cnt,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);
  localparam int IDX_W = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
  localparam int STV_W = $clog2(pSTARVE + 1);
  localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(Tape_Num - 1);
  localparam logic [STV_W-1:0]       STARVE_MAX = STV_W'(pSTARVE);
  localparam logic [pADDR_WIDTH-1:0] TAP_FIRST  = pADDR_WIDTH'(pTAP_BASE);
  localparam logic [pADDR_WIDTH-1:0] TAP_LAST   = pADDR_WIDTH'(pTAP_BASE + 4 * (Tape_Num - 1));

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         init_idx_q, init_idx_d;
  logic [STV_W-1:0]         starve_q, starve_d;
  logic [15:0]              conflict_q, conflict_d;
  logic                     init_done_q, init_done_d;
  logic                     cfg_done_q, cfg_done_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     cfg_rd_q, cfg_rd_d;
  logic                     eng_rvalid_q, eng_rvalid_d;
  logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [pDATA_WIDTH-1:0]   di_q, di_d;
  logic                     cfg_gnt, eng_gnt, addr_ok, cfg_access;

  // State register
  always_ff @(posedge axis_clk) begin
    if (axis_rst) state_q <= S_INIT;
    else          state_q <= state_d;
  end

  // Next-state: walk the clear index once, then stay in RUN until reset
  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    if (state_q == S_INIT) begin
      if (init_idx_q == LAST_IDX) state_d = S_RUN;
      else                        init_idx_d = init_idx_q + IDX_W'(1);
    end
    init_done_d = (state_d == S_RUN);
  end

  // Outputs: grant, RAM pin drive and next values of the response/counter flops
  always_comb begin
    cfg_gnt    = 1'b0;
    eng_gnt    = 1'b0;
    addr_ok    = (bus.cfg_addr >= TAP_FIRST) && (bus.cfg_addr <= TAP_LAST) &&
                 (bus.cfg_addr[1:0] == 2'b00);
    cfg_access = 1'b0;
    tap_EN     = 1'b0;
    tap_WE     = 4'h0;
    tap_A      = addr_q;
    tap_Di     = di_q;
    if (state_q == S_INIT) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = pADDR_WIDTH'({init_idx_q, 2'b00});
      tap_Di = '0;
    end else begin
      // The engine only outranks config while it is running and config is not starved
      if (bus.cfg_req && (!engine_busy || !bus.eng_req || starve_q == STARVE_MAX)) cfg_gnt = 1'b1;
      else if (bus.eng_req)                                                        eng_gnt = 1'b1;
      cfg_access = cfg_gnt && addr_ok && !(bus.cfg_we && engine_busy);
      if (eng_gnt) begin
        tap_EN = 1'b1;
        tap_A  = pADDR_WIDTH'({bus.eng_idx, 2'b00});
      end else if (cfg_access) begin
        tap_EN = 1'b1;
        tap_A  = bus.cfg_addr - TAP_FIRST;
        if (bus.cfg_we) begin
          tap_WE = 4'hF;
          tap_Di = bus.cfg_wdata;
        end
      end
    end
    addr_d       = tap_A;
    di_d         = tap_Di;
    cfg_done_d   = cfg_gnt;
    cfg_err_d    = cfg_gnt && !cfg_access;
    cfg_rd_d     = cfg_access && !bus.cfg_we;
    eng_rvalid_d = eng_gnt;
    starve_d     = starve_q;
    if (cfg_gnt)                                     starve_d = '0;
    else if (bus.cfg_req && starve_q != STARVE_MAX)  starve_d = starve_q + STV_W'(1);
    conflict_d   = conflict_q;
    if (state_q == S_RUN && bus.cfg_req && bus.eng_req && conflict_q != 16'hFFFF)
      conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      init_idx_q   <= '0;
      starve_q     <= '0;
      conflict_q   <= '0;
      init_done_q  <= 1'b0;
      cfg_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_rd_q     <= 1'b0;
      eng_rvalid_q <= 1'b0;
      addr_q       <= '0;
      di_q         <= '0;
    end else begin
      init_idx_q   <= init_idx_d;
      starve_q     <= starve_d;
      conflict_q   <= conflict_d;
      init_done_q  <= init_done_d;
      cfg_done_q   <= cfg_done_d;
      cfg_err_q    <= cfg_err_d;
      cfg_rd_q     <= cfg_rd_d;
      eng_rvalid_q <= eng_rvalid_d;
      addr_q       <= addr_d;
      di_q         <= di_d;
    end
  end

  assign bus.cfg_gnt    = cfg_gnt;
  assign bus.eng_gnt    = eng_gnt;
  assign bus.cfg_done   = cfg_done_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.cfg_rdata  = cfg_rd_q ? tap_Do : '0;
  assign bus.eng_rvalid = eng_rvalid_q;
  assign bus.eng_rdata  = eng_rvalid_q ? tap_Do : '0;
  assign bus.state_dbg  = (state_q == S_RUN);
  assign init_done      = init_done_q;
  assign conflict_cnt   = conflict_q;
endmodule

// File: tb/tb_fir_tap_arbiter.sv
// Directed bench for fir_tap_arbiter: a behavioural RAM on the tap pins, a per-cycle
// reference model of arbitration/responses, and hand-computed literal checks.
module tb_fir_tap_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NTAP = 11;
  localparam int BASE = 'h020;
  localparam int STARVE = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic engine_busy = 1'b0;
  always #5 clk = ~clk;

  logic          init_done;
  logic [15:0]   conflict_cnt;
  logic [3:0]    tap_WE;
  logic          tap_EN;
  logic [DW-1:0] tap_Di;
  logic [DW-1:0] tap_Do = '0;
  logic [AW-1:0] tap_A;

  fir_tap_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fir_tap_arbiter #(
    .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NTAP), .pTAP_BASE(BASE), .pSTARVE(STARVE)
  ) dut (
    .axis_clk(clk), .axis_rst(rst), .engine_busy(engine_busy), .bus(bus),
    .init_done(init_done), .conflict_cnt(conflict_cnt),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do)
  );

  // Behavioural single-port RAM, preloaded with a recognisable pattern
  logic [DW-1:0] ram [0:1023];
  initial for (int i = 0; i < 1024; i++) ram[i] = 32'hDEAD_0000 | 32'(i);
  always @(posedge clk) begin
    if (tap_EN) begin
      tap_Do <= ram[tap_A[AW-1:2]];
      for (int b = 0; b < 4; b++)
        if (tap_WE[b]) ram[tap_A[AW-1:2]][8*b +: 8] = tap_Di[8*b +: 8];
    end
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + compare process ----------------
  int          m_init = 0;
  int          m_starve = 0;
  int          m_conf = 0;
  bit          p_done = 0, p_err = 0, p_rv = 0;
  logic [31:0] p_rdata = '0, p_erd = '0;
  logic [31:0] coef [0:15];
  logic [31:0] exp_q[$];   // cfg read data still owed by the DUT

  initial begin
    bit in_init, eg, cg, ok, acc, en;
    int a, off, ea;
    for (int i = 0; i < 16; i++) coef[i] = 32'hDEAD_0000 | 32'(i);
    forever begin
      @(negedge clk);
      in_init = (m_init < NTAP);
      a       = int'(bus.cfg_addr);
      eg = 0;
      cg = 0;
      if (!in_init) begin
        if (bus.eng_req && engine_busy && m_starve < STARVE) eg = 1;
        else if (bus.cfg_req)                                cg = 1;
        else if (bus.eng_req)                                eg = 1;
      end
      ok  = (a >= BASE) && (a <= BASE + 4 * (NTAP - 1)) && (a % 4 == 0);
      acc = cg && ok && !(bus.cfg_we && engine_busy);
      off = (a - BASE) / 4;
      en  = in_init || eg || acc;
      check32("m_init_done", 32'(init_done), 32'(!in_init));
      check32("m_state_dbg", 32'(bus.state_dbg), 32'(!in_init));
      check32("m_cfg_gnt", 32'(bus.cfg_gnt), 32'(cg));
      check32("m_eng_gnt", 32'(bus.eng_gnt), 32'(eg));
      check32("m_tap_EN", 32'(tap_EN), 32'(en));
      check32("m_tap_WE", 32'(tap_WE), (in_init || (acc && bus.cfg_we)) ? 32'hF : 32'h0);
      if (en) begin
        ea = in_init ? m_init * 4 : (eg ? int'(bus.eng_idx) * 4 : a - BASE);
        check32("m_tap_A", 32'(tap_A), 32'(ea));
      end
      if (in_init) check32("m_tap_Di_init", tap_Di, 32'h0);
      else if (acc && bus.cfg_we) check32("m_tap_Di_wr", tap_Di, bus.cfg_wdata);
      check32("m_cfg_done", 32'(bus.cfg_done), 32'(p_done));
      check32("m_cfg_err", 32'(bus.cfg_err), 32'(p_err));
      check32("m_cfg_rdata", bus.cfg_rdata, p_rdata);
      check32("m_eng_rvalid", 32'(bus.eng_rvalid), 32'(p_rv));
      if (p_rv) check32("m_eng_rdata", bus.eng_rdata, p_erd);
      check32("m_conflict_cnt", 32'(conflict_cnt), 32'(m_conf));

      // advance the model to the next cycle
      p_done  = cg;
      p_err   = cg && !acc;
      p_rdata = '0;
      if (acc && !bus.cfg_we) p_rdata = coef[off];
      p_rv  = eg;
      p_erd = coef[bus.eng_idx];
      if (in_init) coef[m_init] = '0;
      if (acc && bus.cfg_we) coef[off] = bus.cfg_wdata;
      if (cg) m_starve = 0;
      else if (bus.cfg_req && m_starve < STARVE) m_starve++;
      if (!in_init && bus.cfg_req && bus.eng_req && m_conf < 65535) m_conf++;
      if (in_init) m_init++;
      if (rst) begin
        m_init = 0; m_starve = 0; m_conf = 0;
        p_done = 0; p_err = 0; p_rv = 0; p_rdata = '0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_op(input bit busy, input bit we, input logic [11:0] addr, input logic [31:0] wd,
                        output int waited, output logic g_en, output logic [3:0] g_we,
                        output logic [11:0] g_a, output logic d_done, output logic d_err,
                        output logic [31:0] d_rdata);
    tick();
    engine_busy   = busy;
    bus.cfg_req   = 1'b1;
    bus.cfg_we    = we;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = wd;
    waited = 0;
    @(negedge clk);
    while (!bus.cfg_gnt && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.cfg_gnt) begin
      n_checks++;
      n_errors++;
      $display("FAIL cfg_gnt_timeout: got no grant after %0d cycles, required a grant", waited);
    end
    g_en = tap_EN;
    g_we = tap_WE;
    g_a  = tap_A;
    tick();
    bus.cfg_req = 1'b0;
    engine_busy = 1'b0;
    @(negedge clk);
    d_done  = bus.cfg_done;
    d_err   = bus.cfg_err;
    d_rdata = bus.cfg_rdata;
  endtask

  task automatic eng_op(input logic [3:0] idx, output logic gnt, output logic rv, output logic [31:0] rd);
    tick();
    bus.eng_req = 1'b1;
    bus.eng_idx = idx;
    @(negedge clk);
    gnt = bus.eng_gnt;
    tick();
    bus.eng_req = 1'b0;
    @(negedge clk);
    rv = bus.eng_rvalid;
    rd = bus.eng_rdata;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int          w;
    logic        g_en, d_done, d_err, eg, rv;
    logic [3:0]  g_we;
    logic [11:0] g_a;
    logic [31:0] d_rd, rd;
    logic        eg_log [0:7];
    logic        cg_log [0:7];
    logic        dn_log [0:7];
    logic [31:0] rd_log [0:7];
    logic [3:0]  ix_log [0:7];
    logic [15:0] cc_log [0:7];

    bus.cfg_req = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = 12'h020; bus.cfg_wdata = '0;
    bus.eng_req = 1'b0; bus.eng_idx = '0;

    // Reset one edge, then the RAM clear with a config read held throughout
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check32($sformatf("init_done_c%0d", k), 32'(init_done), 32'(k == 11));
      check32($sformatf("init_gnt_c%0d", k), 32'(bus.cfg_gnt), 32'(k == 11));
      if (k < 11) begin
        check32($sformatf("init_tapA_c%0d", k), 32'(tap_A), 32'(k * 4));
        check32($sformatf("init_tapWE_c%0d", k), 32'(tap_WE), 32'hF);
      end
    end
    tick();
    bus.cfg_req = 1'b0;
    @(negedge clk);
    check32("held_read_done", 32'(bus.cfg_done), 32'h1);
    check32("held_read_cleared", bus.cfg_rdata, 32'h0);

    // Idle engine: write then read back tap 0
    cfg_op(1'b0, 1'b1, 12'h020, 32'h5, w, g_en, g_we, g_a, d_done, d_err, d_rd);
    check32("wr20_wait", 32'(w), 32'd0);
    check32("wr20_tapWE", 32'(g_we), 32'hF);
    check32("wr20_tapA", 32'(g_a), 32'h0);
    check32("wr20_done", 32'(d_done), 32'h1);
    check32("wr20_err", 32'(d_err), 32'h0);
    cfg_op(1'b0, 1'b0, 12'h020, 32'h0, w, g_en, g_we, g_a, d_done, d_err, d_rd);
    check32("rd20_data", d_rd, 32'h5);

    // Write while the engine runs is rejected
    cfg_op(1'b1, 1'b1, 12'h024, 32'h7, w, g_en, g_we, g_a, d_done, d_err, d_rd);
    check32("wr24busy_wait", 32'(w), 32'd0);
    check32("wr24busy_tapWE", 32'(g_we), 32'h0);
    check32("wr24busy_tapEN", 32'(g_en), 32'h0);
    check32("wr24busy_err", 32'(d_err), 32'h1);
    cfg_op(1'b0, 1'b0, 12'h024, 32'h0, w, g_en, g_we, g_a, d_done, d_err, d_rd);
    check32("rd24_data", d_rd, 32'h0);
    check32("rd24_err", 32'(d_err), 32'h0);

    // Address boundaries: out of range, misaligned, last tap, below base
    cfg_op(1'b0, 1'b0, 12'h04C, 32'h0, w, g_en, g_we, g_a, d_done, d_err, d_rd);
    check32("rd4C_err", 32'(d_err), 32'h1);
    check32("rd4C_data", d_rd, 32'h0);
    check32("rd4C_tapEN", 32'(g_en), 32'h0);
    cfg_op(1'b0, 1'b0, 12'h022, 32'h0, w, g_en, g_we, g_a, d_done, d_err, d_rd);
    check32("rd22_err", 32'(d_err), 32'h1);
    check32("rd22_data", d_rd, 32'h0);
    check32("rd22_tapEN", 32'(g_en), 32'h0);
    cfg_op(1'b0, 1'b0, 12'h048, 32'h0, w, g_en, g_we, g_a, d_done, d_err, d_rd);
    check32("rd48_err", 32'(d_err), 32'h0);
    check32("rd48_tapA", 32'(g_a), 32'h028);
    cfg_op(1'b0, 1'b0, 12'h01C, 32'h0, w, g_en, g_we, g_a, d_done, d_err, d_rd);
    check32("rd1C_err", 32'(d_err), 32'h1);
    cfg_op(1'b0, 1'b1, 12'h028, 32'hA5A5_0002, w, g_en, g_we, g_a, d_done, d_err, d_rd);
    check32("wr28_err", 32'(d_err), 32'h0);

    // Starvation guard: engine streams taps, config read of 0x028 waits 4 cycles
    tick();
    engine_busy = 1'b1;
    bus.eng_req = 1'b1; bus.eng_idx = 4'd0;
    bus.cfg_req = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = 12'h028;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      eg_log[c] = bus.eng_gnt;  cg_log[c] = bus.cfg_gnt;
      dn_log[c] = bus.cfg_done; rd_log[c] = bus.cfg_rdata;
      ix_log[c] = bus.eng_idx;  cc_log[c] = conflict_cnt;
      tick();
      if (eg_log[c]) bus.eng_idx = (bus.eng_idx == 4'd10) ? 4'd0 : bus.eng_idx + 4'd1;
      if (cg_log[c]) bus.cfg_req = 1'b0;
    end
    bus.eng_req = 1'b0;
    engine_busy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check32($sformatf("starve_eng_gnt_c%0d", c), 32'(eg_log[c]), 32'h1);
      check32($sformatf("starve_cfg_gnt_c%0d", c), 32'(cg_log[c]), 32'h0);
    end
    check32("starve_cfg_gnt_c4", 32'(cg_log[4]), 32'h1);
    check32("starve_eng_gnt_c4", 32'(eg_log[4]), 32'h0);
    check32("starve_idx_held_c4", 32'(ix_log[4]), 32'd4);
    check32("starve_idx_held_c5", 32'(ix_log[5]), 32'd4);
    check32("starve_done_c5", 32'(dn_log[5]), 32'h1);
    check32("starve_rdata_c5", rd_log[5], 32'hA5A5_0002);
    check32("starve_conflict_c5", 32'(cc_log[5]), 32'd5);
    check32("starve_conflict_c7", 32'(cc_log[7]), 32'd5);
    check32("starve_eng_gnt_c5", 32'(eg_log[5]), 32'h1);

    // Engine index beyond the tap count is read without any range check
    eng_op(4'd12, eg, rv, rd);
    check32("eng12_gnt", 32'(eg), 32'h1);
    check32("eng12_rvalid", 32'(rv), 32'h1);
    check32("eng12_rdata", rd, 32'hDEAD_000C);
    eng_op(4'd2, eg, rv, rd);
    check32("eng2_rdata", rd, 32'hA5A5_0002);

    // Reset on the edge that closes an engine grant: the read is dropped
    tick();
    bus.eng_req = 1'b1; bus.eng_idx = 4'd3;
    rst = 1'b1;
    @(negedge clk);
    check32("rst_eng_gnt", 32'(bus.eng_gnt), 32'h1);
    tick();
    bus.eng_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check32("rst_rvalid", 32'(bus.eng_rvalid), 32'h0);
    check32("rst_init_done", 32'(init_done), 32'h0);
    check32("rst_tapA", 32'(tap_A), 32'h0);
    check32("rst_tapWE", 32'(tap_WE), 32'hF);
    check32("rst_conflict", 32'(conflict_cnt), 32'h0);
    for (int k = 1; k < 12; k++) @(negedge clk);
    check32("reinit_done", 32'(init_done), 32'h1);
    eng_op(4'd2, eg, rv, rd);
    check32("reinit_tap2_cleared", rd, 32'h0);
    eng_op(4'd0, eg, rv, rd);
    check32("reinit_tap0_cleared", rd, 32'h0);

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
